// File: rtl/ppcpu_trace_monitor_pkg.sv
// Shared types and sizing helpers for the CPU trace monitor.
package ppcpu_dbg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    POST  = 2'd2,
    DONE  = 2'd3
  } trc_state_t;

  function automatic int aw_of(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int sw_of(input int num_ch, input int width);
    return num_ch * width;
  endfunction

endpackage

// File: rtl/ppcpu_trace_monitor_if.sv
// Readout port of the trace monitor: request in, sample/valid/count out.
interface ppcpu_trace_monitor_if #(
  parameter int SW = 192,
  parameter int AW = 4
);
  logic          rd_en;
  logic [SW-1:0] rd_data;
  logic          rd_valid;
  logic [AW:0]   rd_avail;

  modport master (output rd_en, input rd_data, rd_valid, rd_avail);
  modport slave  (input rd_en, output rd_data, rd_valid, rd_avail);
endinterface

// File: rtl/ppcpu_trace_monitor_ram.sv
// Simple dual-port trace storage; the registered read gives one cycle of readout latency.
module trace_ram #(
  parameter int DEPTH = 16,
  parameter int SW    = 192,
  parameter int AW    = 4
) (
  input  logic          Clock,
  input  logic          Resetn,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [SW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [SW-1:0] rdata
);
  logic [SW-1:0] mem [DEPTH];

  always_ff @(posedge Clock) begin
    if (we) mem[waddr] <= wdata;
  end

  // rdata only moves on a read so the last sample stays visible between reads
  always_ff @(posedge Clock) begin
    if (!Resetn)  rdata <= '0;
    else if (re)  rdata <= mem[raddr];
  end
endmodule

// File: rtl/ppcpu_trace_monitor.sv
// Circular trace capture of CPU probe channels, frozen a programmable distance after a PC trigger.
//   state | meaning
//   IDLE  | waiting for arm
//   ARMED | sampling every cycle, watching pc for the trigger address
//   POST  | sampling the remaining post-trigger cycles
//   DONE  | capture frozen, readout port active
module ppcpu_trace_monitor
  import ppcpu_dbg_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int NUM_CH = 6,
  parameter int DEPTH  = 16,
  parameter int CW     = 16
) (
  input  logic                      Clock,
  input  logic                      Resetn,
  input  logic [NUM_CH*WIDTH-1:0]   probe,
  input  logic [WIDTH-1:0]          pc,
  input  logic [WIDTH-1:0]          trig_pc,
  input  logic [$clog2(DEPTH)-1:0]  post_count,
  input  logic                      arm,
  ppcpu_trace_monitor_if.slave      rd,
  output logic                      done,
  output logic [1:0]                state,
  output logic [CW-1:0]             trig_cycle,
  output logic [CW-1:0]             cycle_count
);
  localparam int AW = aw_of(DEPTH);
  localparam int SW = sw_of(NUM_CH, WIDTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  trc_state_t    st;
  logic [AW-1:0] wr_ptr, rd_ptr, post_left, wr_ptr_nx;
  logic [AW:0]   fill, fill_nx, avail;
  logic          trig, we, re, finish;
  logic [SW-1:0] q;

  assign trig      = (pc == trig_pc);
  assign we        = ((st == ARMED) || (st == POST)) && !arm;
  assign re        = (st == DONE) && !arm && rd.rd_en && (avail != '0);
  assign wr_ptr_nx = wr_ptr + 1'b1;
  assign fill_nx   = (fill == FULL) ? fill : fill + 1'b1;
  assign finish    = we && (((st == ARMED) && trig && (post_count == '0)) ||
                            ((st == POST) && (post_left == AW'(1))));

  assign state       = st;
  assign rd.rd_avail = avail;
  assign rd.rd_data  = q;

  trace_ram #(.DEPTH(DEPTH), .SW(SW), .AW(AW)) u_ram (
    .Clock (Clock),
    .Resetn(Resetn),
    .we    (we),
    .waddr (wr_ptr),
    .wdata (probe),
    .re    (re),
    .raddr (rd_ptr),
    .rdata (q)
  );

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      st          <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fill        <= '0;
      post_left   <= '0;
      avail       <= '0;
      done        <= 1'b0;
      rd.rd_valid <= 1'b0;
      trig_cycle  <= '0;
      cycle_count <= '0;
    end else begin
      if (cycle_count != '1) cycle_count <= cycle_count + 1'b1;
      rd.rd_valid <= re;
      if (arm) begin
        st     <= ARMED;
        wr_ptr <= '0;
        fill   <= '0;
        avail  <= '0;
        done   <= 1'b0;
      end else begin
        case (st)
          ARMED: begin
            wr_ptr <= wr_ptr_nx;
            fill   <= fill_nx;
            if (trig) begin
              trig_cycle <= cycle_count;
              if (post_count == '0) begin
                st <= DONE;
              end else begin
                // the field width already bounds post_count to DEPTH-1
                post_left <= post_count;
                st        <= POST;
              end
            end
          end
          POST: begin
            wr_ptr    <= wr_ptr_nx;
            fill      <= fill_nx;
            post_left <= post_left - 1'b1;
            if (post_left == AW'(1)) st <= DONE;
          end
          DONE: begin
            if (re) begin
              rd_ptr <= rd_ptr + 1'b1;
              avail  <= avail - 1'b1;
            end
          end
          default: ;
        endcase
        if (finish) begin
          done   <= 1'b1;
          avail  <= fill_nx;
          // once the buffer has wrapped, the next write slot holds the oldest sample
          rd_ptr <= (fill_nx == FULL) ? wr_ptr_nx : '0;
        end
      end
    end
  end
endmodule

// File: doc/ppcpu_trace_monitor.md
Name: ppcpu_trace_monitor

Overview:
- Synthesizable, parametrised on-chip trace monitor for the pipelined CPU.
- Continuously samples NUM_CH probe channels (PC, IF_Inst, ID_Inst, EXE_Alu, MEM_Alu, WB_Alu) into a circular buffer.
- Freezes capture a programmable number of cycles after PC matches a trigger address.
- Offers a one-sample-per-request readout port with a cycle-stamp of the trigger, replacing waveform-dump-only debug.

Parameters:
- WIDTH, 32: width of each probe channel.
- NUM_CH, 6: number of probe channels.
- DEPTH, 16: trace buffer entries; power of two, at least 4.
- CW, 16: cycle counter width.

Ports:
- Clock  in  1  system clock, rising edge.
- Resetn  in  1  synchronous, active-low reset.
- probe  in  NUM_CH*WIDTH  concatenated channels; channel 0 in LSBs.
- pc  in  WIDTH  PC compared against trig_pc.
- trig_pc  in  WIDTH  trigger address.
- post_count  in  clog2(DEPTH)  samples captured after the trigger sample.
- arm  in  1  start or restart capture (level sampled per cycle).
- rd_en  in  1  readout request.
- rd_data  out  NUM_CH*WIDTH  read sample.
- rd_valid  out  1  rd_data valid this cycle.
- rd_avail  out  clog2(DEPTH)+1  samples still unread.
- done  out  1  capture complete.
- state  out  2  FSM state code.
- trig_cycle  out  CW  cycle_count value at the trigger sample.
- cycle_count  out  CW  cycles since reset.

Behaviour:
- Reset: the synchronous Resetn=0 check is made on the rising edge of Clock. All of the following go to zero: outputs, wr_ptr, fill, post_left, rd_ptr. state=IDLE. Buffer contents are don't-care.
- cycle_count: +1 every cycle after reset; saturates at all-ones.
- State encoding: IDLE=0, ARMED=1, POST=2, DONE=3.
- IDLE: arm=1 -> ARMED, wr_ptr=0, fill=0.
- ARMED, every cycle:
  - write probe to buf[wr_ptr]; wr_ptr++ mod DEPTH; fill saturates at DEPTH.
  - If pc==trig_pc in the same cycle, that write is the trigger sample and trig_cycle<=cycle_count.
  - On trigger with post_count==0 -> DONE. Otherwise post_left<=min(post_count, DEPTH-1) and -> POST.
- POST: write each cycle, post_left--. The write made while post_left==1 is the last one; -> DONE.
- arm=1 in ARMED or POST restarts: wr_ptr=0, fill=0, stay in or return to ARMED, no write that cycle. arm has priority over trigger.
- DONE entry:
  - done=1, rd_avail=fill.
  - rd_ptr = oldest sample: 0 if fill<DEPTH, else wr_ptr.
- DONE readout:
  - rd_en=1 with rd_avail>0: the next cycle gives rd_valid=1 and rd_data=buf[rd_ptr], then rd_ptr++ mod DEPTH and rd_avail--. Latency is 1 cycle; back-to-back rd_en streams one sample per cycle.
  - rd_en with rd_avail==0: rd_valid=0 and rd_data holds its last value.
- DONE + arm=1 -> ARMED, clearing done, fill and rd_avail. Pending reads are dropped and rd_valid=0 the next cycle.
- rd_en outside DONE is ignored.
- A trigger on the first ARMED cycle is legal: fill=1 at trigger.
- Reset mid-capture or mid-readout returns everything to IDLE next edge; no partial outputs.
- pc match is an exact WIDTH-bit compare. A match during POST is ignored; trig_cycle holds.

Decomposition:
- Package ppcpu_dbg_pkg:
  - state encoding constants IDLE/ARMED/POST/DONE;
  - AW=clog2(DEPTH) helper;
  - SW=NUM_CH*WIDTH sample width.
- Sub-module trace_ram: simple dual-port DEPTH x SW, synchronous write, synchronous registered read. It provides the 1-cycle read latency.
- FSM, pointers and counters stay in ppcpu_trace_monitor.

Test Plan:
- Mid-capture reset:
  - Stimulus: arm, 5 cycles, Resetn=0 for one edge.
  - Required: state=0, done=0, rd_avail=0, cycle_count=0; no trigger until re-armed.
- Long pre-trigger (DEPTH=16):
  - Stimulus: probe=pc=4*n, arm at n=0, trig_pc=80 (n=20), post_count=4.
  - Required: done at n=24, rd_avail=16. Readout yields pc 36..96 in order (trigger sample is the 12th); trig_cycle equals cycle_count at n=20.
- Early trigger:
  - Stimulus: trig_pc=8 (n=2), post_count=2.
  - Required: rd_avail=5; readout 0,4,8,12,16; a sixth rd_en gives rd_valid=0.
- Zero post:
  - Stimulus: post_count=0, trigger at n=10.
  - Required: done next cycle, last sample read = 40.
- Clamp:
  - Stimulus: DEPTH=16, post_count field max, trigger at n=30.
  - Required: 15 post samples captured, oldest read = 120, newest = 180.
- Re-arm mid-readout:
  - Stimulus: read 3 samples, assert arm.
  - Required: done=0, rd_avail=0, rd_valid=0 next cycle, state=ARMED.
